// File: rtl/lc3b_hazard_ctrl.sv
// lc3b_hazard_ctrl: stall/flush/bubble controller for the 5-stage LC-3b pipeline.
// Handles memory-latency freezes, LDI/STI two-access sequencing, MEM-resolved
// branch squashes and (with LC3B_LOAD_USE_STALL_EN defined) load-use bubbles.
// Ports:
//   clk, reset (sync, active-high)
//   dec_src1/src2/dest, dec_uses_sr1/sr2/dest_src : ID-stage operand info
//   ex_load_inst, ex_regfile_write, ex_dest       : EX-stage producer info
//   imem_resp, mem_access, mem_indirect, dmem_resp: memory handshakes
//   mem_br_taken                                  : taken transfer in MEM
//   load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb : reg enables
//   bubble_id_ex, flush_if_id, flush_id_ex, flush_ex_mem      : NOP controls
//   mem_indirect_phase : high during second LDI/STI access
//   stall_cycles, flush_count : saturating performance counters
// Config macro: LC3B_LOAD_USE_STALL_EN (undefined: load-use left to forwarding).
module lc3b_hazard_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       dec_src1,
    input  logic [2:0]       dec_src2,
    input  logic [2:0]       dec_dest,
    input  logic             dec_uses_sr1,
    input  logic             dec_uses_sr2,
    input  logic             dec_uses_dest_src,
    input  logic             ex_load_inst,
    input  logic             ex_regfile_write,
    input  logic [2:0]       ex_dest,
    input  logic             imem_resp,
    input  logic             mem_access,
    input  logic             mem_indirect,
    input  logic             dmem_resp,
    input  logic             mem_br_taken,
    output logic             load_pc,
    output logic             load_if_id,
    output logic             load_id_ex,
    output logic             load_ex_mem,
    output logic             load_mem_wb,
    output logic             bubble_id_ex,
    output logic             flush_if_id,
    output logic             flush_id_ex,
    output logic             flush_ex_mem,
    output logic             mem_indirect_phase,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

`ifdef LC3B_LOAD_USE_STALL_EN
    localparam logic LU_EN = 1'b1;
`else
    localparam logic LU_EN = 1'b0;
`endif

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic {
        RUN,
        IND_SECOND
    } state_t;

    state_t state;
    state_t state_next;

    logic mem_done;
    logic advance;
    logic lu_raw;
    logic lu;
    logic flush;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        mem_done   = 1'b0;
        unique case (state)
            RUN: begin
                mem_done = !mem_access || (dmem_resp && !mem_indirect);
                if (mem_access && mem_indirect && dmem_resp) begin
                    state_next = IND_SECOND;
                end
            end
            IND_SECOND: begin
                mem_done = dmem_resp;
                if (dmem_resp) begin
                    state_next = RUN;
                end
            end
            default: begin
                state_next = RUN;
            end
        endcase
    end

    assign lu_raw = ex_load_inst && ex_regfile_write &&
                    ((dec_uses_sr1 && (dec_src1 == ex_dest)) ||
                     (dec_uses_sr2 && (dec_src2 == ex_dest)) ||
                     (dec_uses_dest_src && (dec_dest == ex_dest)));

    // Without the stall option, forwarding covers load-use, so lu is inert.
    assign lu = lu_raw && LU_EN;

    // Gating advance with reset forces every enable/flush/bubble low in reset.
    assign advance = !reset && imem_resp && mem_done;
    assign flush   = advance && mem_br_taken;

    assign load_id_ex   = advance;
    assign load_ex_mem  = advance;
    assign load_mem_wb  = advance;
    assign flush_if_id  = flush;
    assign flush_id_ex  = flush;
    assign flush_ex_mem = flush;

    // A squash replaces the ID instruction, so it overrides the bubble.
    assign load_pc      = advance && (mem_br_taken || !lu);
    assign load_if_id   = advance && (mem_br_taken || !lu);
    assign bubble_id_ex = advance && lu && !mem_br_taken;

    assign mem_indirect_phase = (state == IND_SECOND);

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if (!advance && (stall_cycles != CNT_MAX)) begin
                stall_cycles <= stall_cycles + CNT_ONE;
            end
            if (flush && (flush_count != CNT_MAX)) begin
                flush_count <= flush_count + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_lc3b_hazard_ctrl.sv
// tb_lc3b_hazard_ctrl: directed plus randomized checks of lc3b_hazard_ctrl
// against a behavioural model; a CNT_W=4 instance covers counter saturation.
module tb_lc3b_hazard_ctrl;

    logic       clk;
    logic       reset;
    logic [2:0] dec_src1, dec_src2, dec_dest, ex_dest;
    logic       dec_uses_sr1, dec_uses_sr2, dec_uses_dest_src;
    logic       ex_load_inst, ex_regfile_write;
    logic       imem_resp, mem_access, mem_indirect, dmem_resp, mem_br_taken;

    logic        load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb;
    logic        bubble_id_ex, flush_if_id, flush_id_ex, flush_ex_mem;
    logic        mem_indirect_phase;
    logic [15:0] stall_cycles, flush_count;

    logic       s_load_pc, s_load_if_id, s_load_id_ex, s_load_ex_mem;
    logic       s_load_mem_wb, s_bubble, s_flush_if_id, s_flush_id_ex;
    logic       s_flush_ex_mem, s_phase;
    logic [3:0] s_stall, s_flush;

    int tests;
    int failed;

    // Model state: in-second-access flag and unbounded-then-clamped counts.
    bit m_ind;
    int m_stall, m_flush, m_stall4, m_flush4;
    bit regs_valid;

    lc3b_hazard_ctrl #(.CNT_W(16)) dut (
        .clk(clk), .reset(reset),
        .dec_src1(dec_src1), .dec_src2(dec_src2), .dec_dest(dec_dest),
        .dec_uses_sr1(dec_uses_sr1), .dec_uses_sr2(dec_uses_sr2),
        .dec_uses_dest_src(dec_uses_dest_src),
        .ex_load_inst(ex_load_inst), .ex_regfile_write(ex_regfile_write),
        .ex_dest(ex_dest), .imem_resp(imem_resp), .mem_access(mem_access),
        .mem_indirect(mem_indirect), .dmem_resp(dmem_resp),
        .mem_br_taken(mem_br_taken),
        .load_pc(load_pc), .load_if_id(load_if_id), .load_id_ex(load_id_ex),
        .load_ex_mem(load_ex_mem), .load_mem_wb(load_mem_wb),
        .bubble_id_ex(bubble_id_ex), .flush_if_id(flush_if_id),
        .flush_id_ex(flush_id_ex), .flush_ex_mem(flush_ex_mem),
        .mem_indirect_phase(mem_indirect_phase),
        .stall_cycles(stall_cycles), .flush_count(flush_count)
    );

    lc3b_hazard_ctrl #(.CNT_W(4)) dut4 (
        .clk(clk), .reset(reset),
        .dec_src1(dec_src1), .dec_src2(dec_src2), .dec_dest(dec_dest),
        .dec_uses_sr1(dec_uses_sr1), .dec_uses_sr2(dec_uses_sr2),
        .dec_uses_dest_src(dec_uses_dest_src),
        .ex_load_inst(ex_load_inst), .ex_regfile_write(ex_regfile_write),
        .ex_dest(ex_dest), .imem_resp(imem_resp), .mem_access(mem_access),
        .mem_indirect(mem_indirect), .dmem_resp(dmem_resp),
        .mem_br_taken(mem_br_taken),
        .load_pc(s_load_pc), .load_if_id(s_load_if_id),
        .load_id_ex(s_load_id_ex), .load_ex_mem(s_load_ex_mem),
        .load_mem_wb(s_load_mem_wb), .bubble_id_ex(s_bubble),
        .flush_if_id(s_flush_if_id), .flush_id_ex(s_flush_id_ex),
        .flush_ex_mem(s_flush_ex_mem), .mem_indirect_phase(s_phase),
        .stall_cycles(s_stall), .flush_count(s_flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit model_lu();
        bit hit;
        hit = (dec_uses_sr1 && dec_src1 == ex_dest) ||
              (dec_uses_sr2 && dec_src2 == ex_dest) ||
              (dec_uses_dest_src && dec_dest == ex_dest);
`ifdef LC3B_LOAD_USE_STALL_EN
        return ex_load_inst && ex_regfile_write && hit;
`else
        return 1'b0 && hit;
`endif
    endfunction

    // The pipeline moves only if fetch is done and MEM's whole access
    // (both halves for LDI/STI) finishes this cycle.
    function automatic bit model_adv();
        bit mem_ok;
        if (m_ind) mem_ok = dmem_resp;
        else if (!mem_access) mem_ok = 1'b1;
        else mem_ok = dmem_resp && !mem_indirect;
        return !reset && imem_resp && mem_ok;
    endfunction

    task automatic settle();
        bit adv, lu, br;
        #2;
        adv = model_adv();
        lu  = model_lu();
        br  = mem_br_taken;
        chk("load_pc", load_pc, adv && (br || !lu));
        chk("load_if_id", load_if_id, adv && (br || !lu));
        chk("load_id_ex", load_id_ex, adv);
        chk("load_ex_mem", load_ex_mem, adv);
        chk("load_mem_wb", load_mem_wb, adv);
        chk("bubble", bubble_id_ex, adv && lu && !br);
        chk("flush_if_id", flush_if_id, adv && br);
        chk("flush_id_ex", flush_id_ex, adv && br);
        chk("flush_ex_mem", flush_ex_mem, adv && br);
        chk("s_load_pc", s_load_pc, adv && (br || !lu));
        if (regs_valid) begin
            chk("phase", mem_indirect_phase, m_ind);
            chk("stall_cycles", stall_cycles, m_stall);
            chk("flush_count", flush_count, m_flush);
            chk("s_phase", s_phase, m_ind);
            chk("s_stall", s_stall, m_stall4);
            chk("s_flush", s_flush, m_flush4);
        end
    endtask

    task automatic tick();
        bit adv;
        adv = model_adv();
        @(posedge clk);
        if (reset) begin
            m_ind = 1'b0;
            m_stall = 0; m_flush = 0; m_stall4 = 0; m_flush4 = 0;
            regs_valid = 1'b1;
        end else begin
            if (m_ind) begin
                if (dmem_resp) m_ind = 1'b0;
            end else if (mem_access && mem_indirect && dmem_resp) begin
                m_ind = 1'b1;
            end
            if (!adv) begin
                m_stall  = (m_stall  + 1 > 65535) ? 65535 : m_stall + 1;
                m_stall4 = (m_stall4 + 1 > 15) ? 15 : m_stall4 + 1;
            end
            if (adv && mem_br_taken) begin
                m_flush  = (m_flush  + 1 > 65535) ? 65535 : m_flush + 1;
                m_flush4 = (m_flush4 + 1 > 15) ? 15 : m_flush4 + 1;
            end
        end
        @(negedge clk);
    endtask

    task automatic step();
        settle();
        tick();
    endtask

    task automatic idle();
        reset = 1'b0;
        dec_src1 = 3'd0; dec_src2 = 3'd0; dec_dest = 3'd0; ex_dest = 3'd0;
        dec_uses_sr1 = 1'b0; dec_uses_sr2 = 1'b0; dec_uses_dest_src = 1'b0;
        ex_load_inst = 1'b0; ex_regfile_write = 1'b0;
        imem_resp = 1'b1; mem_access = 1'b0; mem_indirect = 1'b0;
        dmem_resp = 1'b0; mem_br_taken = 1'b0;
    endtask

    initial begin
        tests = 0;
        failed = 0;
        regs_valid = 1'b0;
        m_ind = 1'b0;
        m_stall = 0; m_flush = 0; m_stall4 = 0; m_flush4 = 0;

        // Reset with every input high.
        reset = 1'b1;
        dec_src1 = 3'd7; dec_src2 = 3'd7; dec_dest = 3'd7; ex_dest = 3'd7;
        dec_uses_sr1 = 1'b1; dec_uses_sr2 = 1'b1; dec_uses_dest_src = 1'b1;
        ex_load_inst = 1'b1; ex_regfile_write = 1'b1;
        imem_resp = 1'b1; mem_access = 1'b1; mem_indirect = 1'b1;
        dmem_resp = 1'b1; mem_br_taken = 1'b1;
        settle();
        chk("rst_load_pc", load_pc, 1'b0);
        chk("rst_flush", flush_if_id, 1'b0);
        tick();
        step();
        chk("rst_phase", mem_indirect_phase, 1'b0);
        chk("rst_stall", stall_cycles, 16'd0);
        chk("rst_flushcnt", flush_count, 16'd0);

        // Release: everything advances.
        idle();
        settle();
        chk("rel_load_pc", load_pc, 1'b1);
        chk("rel_load_mem_wb", load_mem_wb, 1'b1);
        tick();

        // Data stall: 3 waiting cycles, then response.
        mem_access = 1'b1;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("dstall_frozen", load_id_ex, 1'b0);
            tick();
        end
        dmem_resp = 1'b1;
        settle();
        chk("dstall_go", load_id_ex, 1'b1);
        tick();
        chk("dstall_count", stall_cycles, 16'd3);

        // LDI with responses at cycles 0 and 2.
        mem_indirect = 1'b1;
        settle();
        chk("ldi_c0_hold", load_mem_wb, 1'b0);
        tick();
        chk("ldi_c1_phase", mem_indirect_phase, 1'b1);
        dmem_resp = 1'b0;
        step();
        chk("ldi_c2_phase", mem_indirect_phase, 1'b1);
        dmem_resp = 1'b1;
        settle();
        chk("ldi_c2_go", load_mem_wb, 1'b1);
        tick();
        chk("ldi_phase_done", mem_indirect_phase, 1'b0);
        chk("ldi_stall", stall_cycles, 16'd5);

        // Branch resolved while fetch is frozen.
        idle();
        mem_br_taken = 1'b1;
        imem_resp = 1'b0;
        for (int i = 0; i < 2; i++) begin
            settle();
            chk("br_frozen_flush", flush_id_ex, 1'b0);
            tick();
        end
        imem_resp = 1'b1;
        settle();
        chk("br_flush", flush_ex_mem, 1'b1);
        chk("br_load_pc", load_pc, 1'b1);
        tick();
        mem_br_taken = 1'b0;
        settle();
        chk("br_flush_once", flush_if_id, 1'b0);
        tick();
        chk("br_flushcnt", flush_count, 16'd1);

        // Load-use on SR2 = R3.
        ex_load_inst = 1'b1; ex_regfile_write = 1'b1;
        ex_dest = 3'd3; dec_src2 = 3'd3; dec_uses_sr2 = 1'b1;
        settle();
`ifdef LC3B_LOAD_USE_STALL_EN
        chk("lu_bubble", bubble_id_ex, 1'b1);
        chk("lu_load_pc", load_pc, 1'b0);
        chk("lu_load_if_id", load_if_id, 1'b0);
`else
        chk("lu_bubble", bubble_id_ex, 1'b0);
        chk("lu_load_pc", load_pc, 1'b1);
`endif
        tick();
        mem_br_taken = 1'b1;
        settle();
        chk("lu_br_bubble", bubble_id_ex, 1'b0);
        chk("lu_br_flush", flush_id_ex, 1'b1);
        tick();

        // Reset asserted during the second indirect access.
        idle();
        mem_access = 1'b1; mem_indirect = 1'b1; dmem_resp = 1'b1;
        step();
        chk("mid_ind_phase", mem_indirect_phase, 1'b1);
        reset = 1'b1;
        dmem_resp = 1'b0;
        settle();
        chk("mid_rst_load", load_mem_wb, 1'b0);
        tick();
        chk("mid_rst_phase", mem_indirect_phase, 1'b0);
        chk("mid_rst_stall", stall_cycles, 16'd0);

        // Saturation on the 4-bit instance.
        idle();
        imem_resp = 1'b0;
        for (int i = 0; i < 20; i++) step();
        chk("sat4_stall", s_stall, 4'hF);
        chk("sat16_stall", stall_cycles, 16'd20);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            reset = ($urandom_range(0, 24) == 0);
            dec_src1 = 3'($urandom); dec_src2 = 3'($urandom);
            dec_dest = 3'($urandom); ex_dest = 3'($urandom_range(0, 3));
            dec_src1[2] = 1'b0;
            dec_uses_sr1 = 1'($urandom); dec_uses_sr2 = 1'($urandom);
            dec_uses_dest_src = 1'($urandom);
            ex_load_inst = 1'($urandom); ex_regfile_write = 1'($urandom);
            imem_resp = ($urandom_range(0, 3) != 0);
            mem_access = 1'($urandom);
            mem_indirect = ($urandom_range(0, 2) == 0);
            dmem_resp = 1'($urandom);
            mem_br_taken = ($urandom_range(0, 3) == 0);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/lc3b_hazard_ctrl.md
# lc3b_hazard_ctrl

Pipeline hazard and stall controller for the 5-stage LC-3b pipeline. It acts on the hazards that `forwarding_unit` cannot resolve:
- memory-latency stalls on the instruction and data ports;
- LDI/STI two-access sequencing;
- control-transfer squashes resolved in MEM;
- optionally, load-use bubbles.

It drives every pipeline-register load enable plus the flush/bubble controls. It also keeps two saturating performance counters.

## Interface
Parameters:
- `CNT_W`, 16, width of performance counters

Ports:
- `clk`  in  1  pipeline clock
- `reset`  in  1  synchronous, active-high
- `dec_src1`, `dec_src2`, `dec_dest`  in  3 each (`lc3b_reg`)  register fields of the instruction in ID
- `dec_uses_sr1`, `dec_uses_sr2`, `dec_uses_dest_src`  in  1 each  ID instruction reads SR1 / SR2 / DR-as-source (stores)
- `ex_load_inst`  in  1  instruction in EX is LDR/LDB/LDI
- `ex_regfile_write`  in  1  EX instruction writes the regfile
- `ex_dest`  in  3  EX destination register
- `imem_resp`  in  1  instruction fetch complete this cycle
- `mem_access`  in  1  MEM instruction needs data memory
- `mem_indirect`  in  1  MEM instruction is LDI/STI
- `dmem_resp`  in  1  data access complete this cycle
- `mem_br_taken`  in  1  taken BR/JMP/JSR/TRAP resolved in MEM
- `load_pc`, `load_if_id`, `load_id_ex`, `load_ex_mem`, `load_mem_wb`  out  1 each  register enables
- `bubble_id_ex`  out  1  load NOP into ID/EX
- `flush_if_id`, `flush_id_ex`, `flush_ex_mem`  out  1 each  squash to NOP
- `mem_indirect_phase`  out  1  registered; 1 during the second LDI/STI access
- `stall_cycles`  out  CNT_W  frozen-cycle count
- `flush_count`  out  CNT_W  squash-event count

## Operation
States: RUN, IND_SECOND. `mem_indirect_phase` = (state == IND_SECOND).

State transitions:
- RUN → IND_SECOND when `mem_access && mem_indirect && dmem_resp`.
- IND_SECOND → RUN when `dmem_resp`.
- All other cases: hold state.

`mem_done`:
- RUN: `!mem_access || (dmem_resp && !mem_indirect)`.
- IND_SECOND: `dmem_resp`.

`advance` = `imem_resp && mem_done`. Any pending memory freezes the whole pipeline.

`lu` (load-use hazard) = `ex_load_inst && ex_regfile_write && ((dec_uses_sr1 && dec_src1==ex_dest) || (dec_uses_sr2 && dec_src2==ex_dest) || (dec_uses_dest_src && dec_dest==ex_dest))`. It is gated by the configuration macro.

Output equations:
- `load_id_ex` = `load_ex_mem` = `load_mem_wb` = `advance`.
- `flush_if_id` = `flush_id_ex` = `flush_ex_mem` = `advance && mem_br_taken`.
- `load_pc` = `load_if_id` = `advance && (mem_br_taken || !lu)`.
- `bubble_id_ex` = `advance && lu && !mem_br_taken`.

Priority: branch squash beats load-use. The ID instruction is flushed, so no bubble is needed.

Counters:
- `stall_cycles` increments on each non-reset cycle with `!advance`.
- `flush_count` increments on each flush cycle.
- Both saturate at all-ones and never wrap.

## Timing
- All enable, flush and bubble outputs are combinational from the inputs and the current state, in the same cycle.
- `mem_indirect_phase` and both counters are registered; each update is visible the cycle after its event.
- Reset (synchronous; also when asserted mid-stall or mid-indirect):
  - next state is RUN; `mem_indirect_phase`=0; both counters 0.
  - while `reset`=1, every load/flush/bubble output is forced to 0.
- Branch resolved while frozen: flushes are asserted only on the cycle `advance` rises, never earlier, and for exactly one cycle.
- `imem_resp` and `dmem_resp` in the same cycle: advance that cycle.
- `imem_resp` alone while the data port is still waiting: no advance. The fetch unit holds the fetched word.
- LDI/STI with `dmem_resp` on every cycle: minimum two MEM cycles. Cycle 1 transitions to IND_SECOND without advancing; cycle 2 advances.

## Configuration
- `LC3B_LOAD_USE_STALL_EN` defined:
  - `lu` is computed as above, inserting one bubble per load-use hazard.
  - Used when data memory cannot forward from MEM to EX within the same cycle.
- Not defined:
  - `lu` is tied to 0; `bubble_id_ex` is constant 0.
  - Load-use hazards are resolved by `forwarding_unit`'s MEM-to-EX load path (select `2'b11`).

## Test plan
- **Reset:** hold `reset` 2 cycles with all inputs 1 → all enables 0, counters 0, `mem_indirect_phase`=0; release with `imem_resp`=1, `mem_access`=0 → all five load enables 1 next cycle.
- **Data stall:** `mem_access`=1, `dmem_resp`=0 for 3 cycles, then 1 → enables 0 for 3 cycles, 1 on the 4th; `stall_cycles`=3 afterward.
- **LDI:** `mem_indirect`=1, `dmem_resp` pulses at cycles 0 and 2 → `mem_indirect_phase`=1 for cycles 1–2; advance only at cycle 2; `stall_cycles`=2.
- **Branch during freeze:** `mem_br_taken`=1 with `imem_resp`=0 for 2 cycles, then 1 → flushes 0, 0, then 1 for one cycle; `load_pc`=1 on that cycle; `flush_count`=1.
- **Load-use (macro on):** `ex_load_inst`=1, `ex_dest`=R3, `dec_src2`=R3, `dec_uses_sr2`=1 → `bubble_id_ex`=1, `load_pc`=`load_if_id`=0. Same stimulus with `mem_br_taken`=1 → bubble 0, flushes 1. Macro off → bubble 0, `load_pc`=1.
- **Saturation:** force counter to all-ones via CNT_W=4 with 20 stall cycles → `stall_cycles`=4'hF, no wrap.
